// File: rtl/bomberman_pkg.sv
// Shared map geometry and direction encoding for the player, obstacle checker and renderer.
package bomberman_pkg;

    // Values double as bit indices into the obstacle checker's 4-bit flag vector.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        MV_IDLE   = 2'd0,
        MV_STEP   = 2'd1,
        MV_SETTLE = 2'd2
    } move_state_t;

    localparam int TILE_PX = 32;
    localparam int NUM_ROW = 11;
    localparam int NUM_COL = 19;
    localparam int X_W     = 11;
    localparam int Y_W     = 10;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Buttons and obstacle flags in, player position and pose out.
interface player_move_ctrl_if;
    import bomberman_pkg::*;

    logic           btn_up;
    logic           btn_down;
    logic           btn_left;
    logic           btn_right;
    logic [3:0]     obstacles;
    logic [X_W-1:0] player_x;
    logic [Y_W-1:0] player_y;
    dir_t           facing;
    logic           moving;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, obstacles,
        input  player_x, player_y, facing, moving
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, obstacles,
        output player_x, player_y, facing, moving
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, on the last count.
module tick_gen #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player position owner: one gated pixel step per tick, then a hold so the
// obstacle checker can re-sweep all four directions at the new position.
module player_move_ctrl
    import bomberman_pkg::*;
#(
    parameter int NUM_ROW       = bomberman_pkg::NUM_ROW,
    parameter int NUM_COL       = bomberman_pkg::NUM_COL,
    parameter int TILE_PX       = bomberman_pkg::TILE_PX,
    parameter int START_X       = 32,
    parameter int START_Y       = 32,
    parameter int STEP_DIV      = 1_000_000,
    parameter int SETTLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    player_move_ctrl_if.slave io
);

    localparam logic [X_W-1:0] X_MAX = X_W'(NUM_COL * TILE_PX - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(NUM_ROW * TILE_PX - 1);
    localparam int             SC_W  = $clog2(SETTLE_CYCLES);

    move_state_t     state_q, state_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    dir_t            facing_q, facing_d;
    logic [SC_W-1:0] cnt_q, cnt_d;

    logic tick;
    logic req_vld;
    dir_t req_dir;
    logic bound_ok;

    tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_UP;
        if      (io.btn_up)    req_dir = DIR_UP;
        else if (io.btn_down)  req_dir = DIR_DOWN;
        else if (io.btn_left)  req_dir = DIR_LEFT;
        else if (io.btn_right) req_dir = DIR_RIGHT;
        else                   req_vld = 1'b0;
    end

    // Edge guard keeps the unsigned position arithmetic from ever wrapping.
    always_comb begin
        bound_ok = 1'b1;
        case (req_dir)
            DIR_UP:    bound_ok = (y_q != '0);
            DIR_DOWN:  bound_ok = (y_q != Y_MAX);
            DIR_LEFT:  bound_ok = (x_q != '0);
            DIR_RIGHT: bound_ok = (x_q != X_MAX);
            default:   bound_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        cnt_d    = cnt_q;
        case (state_q)
            MV_IDLE: begin
                if (tick && req_vld) begin
                    facing_d = req_dir;
                    if (!io.obstacles[req_dir] && bound_ok) state_d = MV_STEP;
                end
            end
            MV_STEP: begin
                // facing_q holds the direction that was accepted in IDLE.
                case (facing_q)
                    DIR_UP:    y_d = y_q - Y_W'(1);
                    DIR_DOWN:  y_d = y_q + Y_W'(1);
                    DIR_LEFT:  x_d = x_q - X_W'(1);
                    DIR_RIGHT: x_d = x_q + X_W'(1);
                    default:   ;
                endcase
                cnt_d   = '0;
                state_d = MV_SETTLE;
            end
            MV_SETTLE: begin
                if (cnt_q == SC_W'(SETTLE_CYCLES - 1)) state_d = MV_IDLE;
                else                                   cnt_d   = cnt_q + SC_W'(1);
            end
            default: state_d = MV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MV_IDLE;
            x_q      <= X_W'(START_X);
            y_q      <= Y_W'(START_Y);
            facing_q <= DIR_DOWN;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            cnt_q    <= cnt_d;
        end
    end

    assign io.player_x = x_q;
    assign io.player_y = y_q;
    assign io.facing   = facing_q;
    assign io.moving   = (state_q != MV_IDLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: three instances cover default start,
// edge starts (0,351) and a fast tick that lands inside SETTLE.
module tb_player_move_ctrl;
    import bomberman_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    player_move_ctrl_if if_a ();
    player_move_ctrl_if if_b ();
    player_move_ctrl_if if_c ();

    player_move_ctrl #(.START_X(32), .START_Y(32),  .STEP_DIV(8), .SETTLE_CYCLES(4)) dut_a (
        .clk (clk), .rst (rst), .io (if_a));
    player_move_ctrl #(.START_X(0),  .START_Y(351), .STEP_DIV(8), .SETTLE_CYCLES(4)) dut_b (
        .clk (clk), .rst (rst), .io (if_b));
    player_move_ctrl #(.START_X(32), .START_Y(32),  .STEP_DIV(2), .SETTLE_CYCLES(4)) dut_c (
        .clk (clk), .rst (rst), .io (if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mv(input int w);
        case (w)
            0:       return int'(if_a.moving);
            1:       return int'(if_b.moving);
            default: return int'(if_c.moving);
        endcase
    endfunction

    function automatic int px(input int w);
        case (w)
            0:       return int'(if_a.player_x);
            1:       return int'(if_b.player_x);
            default: return int'(if_c.player_x);
        endcase
    endfunction

    // Counts negedges until moving is seen high, then the width of that pulse.
    // Returns sitting on the first low sample after the pulse.
    task automatic measure(input int w, output int lat, output int width, output int x_rise);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mv(w) == 0 && lat < 100);
        x_rise = px(w);
        width  = 0;
        while (mv(w) == 1 && width < 100) begin
            width++;
            @(negedge clk);
        end
    endtask

    task automatic count_moving(input int w, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hi += mv(w);
        end
    endtask

    initial begin
        int lat, width, xr, hi;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        {if_a.btn_up, if_a.btn_down, if_a.btn_left, if_a.btn_right} = '0;
        {if_b.btn_up, if_b.btn_down, if_b.btn_left, if_b.btn_right} = '0;
        {if_c.btn_up, if_c.btn_down, if_c.btn_left, if_c.btn_right} = '0;
        if_a.obstacles = '0;
        if_b.obstacles = '0;
        if_c.obstacles = '0;
        repeat (3) @(negedge clk);

        chk("rst_x",      int'(if_a.player_x), 32);
        chk("rst_y",      int'(if_a.player_y), 32);
        chk("rst_facing", int'(if_a.facing),   int'(DIR_DOWN));
        chk("rst_moving", int'(if_a.moving),   0);
        chk("rst_b_x",    int'(if_b.player_x), 0);
        chk("rst_b_y",    int'(if_b.player_y), 351);

        // Right held from reset release: first tick is the 7th cycle, then every 8.
        rst            = 1'b0;
        if_a.btn_right = 1'b1;
        for (int p = 0; p < 3; p++) begin
            measure(0, lat, width, xr);
            chk($sformatf("right_lat%0d", p),   lat,   (p == 0) ? 8 : 3);
            chk($sformatf("right_width%0d", p), width, 5);
            chk($sformatf("right_xrise%0d", p), xr,    32 + p);
            chk($sformatf("right_xend%0d", p),  px(0), 33 + p);
        end
        chk("right_y",      int'(if_a.player_y), 32);
        chk("right_facing", int'(if_a.facing),   int'(DIR_RIGHT));

        // Up blocked by an obstacle: facing turns, nothing moves.
        if_a.btn_right = 1'b0;
        if_a.btn_up    = 1'b1;
        if_a.obstacles = 4'b0001;
        count_moving(0, 40, hi);
        chk("blk_moving", hi,                  0);
        chk("blk_x",      int'(if_a.player_x), 35);
        chk("blk_y",      int'(if_a.player_y), 32);
        chk("blk_facing", int'(if_a.facing),   int'(DIR_UP));
        if_a.btn_up    = 1'b0;
        if_a.obstacles = '0;

        // Map edges: left at x==0 and down at y==351 are refused without obstacles.
        if_b.btn_left = 1'b1;
        count_moving(1, 40, hi);
        chk("left_edge_moving", hi,                  0);
        chk("left_edge_x",      int'(if_b.player_x), 0);
        chk("left_edge_facing", int'(if_b.facing),   int'(DIR_LEFT));
        if_b.btn_left = 1'b0;
        if_b.btn_down = 1'b1;
        count_moving(1, 40, hi);
        chk("down_edge_moving", hi,                  0);
        chk("down_edge_y",      int'(if_b.player_y), 351);
        chk("down_edge_facing", int'(if_b.facing),   int'(DIR_DOWN));
        if_b.btn_down = 1'b0;

        // Tick every 2 cycles: ticks inside SETTLE must neither move nor queue.
        if_c.btn_right = 1'b1;
        for (int p = 0; p < 3; p++) begin
            measure(2, lat, width, xr);
            if (p > 0) chk($sformatf("fast_lat%0d", p), lat, 1);
            chk($sformatf("fast_width%0d", p), width, 5);
            chk($sformatf("fast_xend%0d", p),  px(2), 33 + p);
        end
        if_c.btn_right = 1'b0;
        count_moving(2, 10, hi);
        chk("fast_x_final", int'(if_c.player_x), 35);

        // Up+right after a fresh reset: up wins.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        if_a.btn_up    = 1'b1;
        if_a.btn_right = 1'b1;
        rst            = 1'b0;
        measure(0, lat, width, xr);
        chk("prio_lat",    lat,                 8);
        chk("prio_width",  width,               5);
        chk("prio_x",      int'(if_a.player_x), 32);
        chk("prio_y",      int'(if_a.player_y), 31);
        chk("prio_facing", int'(if_a.facing),   int'(DIR_UP));
        if_a.btn_up = 1'b0;

        // Reset landing in the STEP cycle discards the step.
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (if_a.moving == 1'b0 && lat < 100);
        chk("mid_step_seen", int'(if_a.moving), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_x",      int'(if_a.player_x), 32);
        chk("mid_rst_y",      int'(if_a.player_y), 32);
        chk("mid_rst_facing", int'(if_a.facing),   int'(DIR_DOWN));
        chk("mid_rst_moving", int'(if_a.moving),   0);
        repeat (3) @(negedge clk);
        chk("mid_rst_hold_x", int'(if_a.player_x), 32);
        rst            = 1'b0;
        if_a.btn_right = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
